// File: rtl/trap_pkg.sv
// trap_pkg: shared CSR addresses, cause codes, write modes, mstatus fields and sequencer states
package trap_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [31:0] CAUSE_IRQ         = 32'h8000000B;
    localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
    localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
    localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
    localparam logic [31:0] CAUSE_ECALL       = 32'd11;
    localparam logic [1:0] WSC_W = 2'b01;
    localparam logic [1:0] WSC_S = 2'b10;
    localparam logic [1:0] WSC_C = 2'b11;
    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_HI = 12;
    localparam int MPP_LO = 11;
    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_TVAL,
        SET_STATUS,
        TRAP_JUMP,
        RESTORE_STATUS,
        RET_JUMP
    } state_t;
endpackage

// File: rtl/trap_priority_enc.sv
// trap_priority_enc: ranks pipeline events and picks the trap cause, EPC source and TVAL source
module trap_priority_enc
    import trap_pkg::*;
(
    input  logic        interrupt,
    input  logic        illegal_inst,
    input  logic        l_access_fault,
    input  logic        s_access_fault,
    input  logic        ecall_m,
    input  logic        mret,
    input  logic        mie,
    output logic        valid,
    output logic [31:0] cause,
    output logic        epc_sel,
    output logic        tval_sel,
    output logic        is_mret
);
    logic irq;
    logic exc;
    always_comb begin
        irq      = interrupt && mie;
        exc      = irq || illegal_inst || ecall_m || l_access_fault || s_access_fault;
        valid    = exc || mret;
        is_mret  = mret && !exc;
        cause    = irq ? CAUSE_IRQ : illegal_inst ? CAUSE_ILLEGAL : ecall_m ? CAUSE_ECALL :
                   l_access_fault ? CAUSE_LOAD_FAULT : s_access_fault ? CAUSE_STORE_FAULT : '0;
        epc_sel  = irq;
        tval_sel = !irq && (illegal_inst || (!ecall_m && (l_access_fault || s_access_fault)));
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: owns the CSR write port and sequences trap entry and mret return
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [11:0] MTVEC_ADDR   = CSR_MTVEC,
    parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
    parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE,
    parameter logic [11:0] MTVAL_ADDR   = CSR_MTVAL,
    parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    input  logic [11:0] csr_req_addr,
    input  logic [31:0] csr_req_wdata,
    input  logic [1:0]  csr_req_wsc,
    output logic        csr_req_ready,
    input  logic        interrupt,
    input  logic        illegal_inst,
    input  logic        l_access_fault,
    input  logic        s_access_fault,
    input  logic        ecall_m,
    input  logic        mret,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic [31:0] fault_val,
    input  logic [31:0] mstatus,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_raddr,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc,
    output logic        flush,
    output logic        stall,
    output logic        RegWrite_cancel,
    output logic        redirect_valid,
    output logic [31:0] PC_redirect,
    output logic        busy
);
    state_t      state, next_state, cur;
    logic [31:0] cause_q, epc_q, tval_q;
    logic        ev_valid, epc_sel, tval_sel, is_mret;
    logic [31:0] ev_cause, set_status, ret_status;
    logic        ev, trap_ev, fwd, save;

    trap_priority_enc u_enc (
        .interrupt      (interrupt),
        .illegal_inst   (illegal_inst),
        .l_access_fault (l_access_fault),
        .s_access_fault (s_access_fault),
        .ecall_m        (ecall_m),
        .mret           (mret),
        .mie            (mstatus[MIE]),
        .valid          (ev_valid),
        .cause          (ev_cause),
        .epc_sel        (epc_sel),
        .tval_sel       (tval_sel),
        .is_mret        (is_mret)
    );

    always_comb begin
        // While reset is held, behave as an idle sequencer that accepts nothing
        cur             = rst ? state : IDLE;
        ev              = rst && cur == IDLE && ev_valid;
        trap_ev         = ev && !is_mret;
        fwd             = rst && cur == IDLE && !ev && csr_req_valid;
        busy            = cur != IDLE;
        stall           = busy;
        flush           = ev;
        RegWrite_cancel = trap_ev && !epc_sel;
        csr_req_ready   = cur == IDLE && !ev;
        set_status                = mstatus;
        set_status[MPIE]          = mstatus[MIE];
        set_status[MIE]           = 1'b0;
        set_status[MPP_HI:MPP_LO] = 2'b11;
        ret_status                = mstatus;
        ret_status[MIE]           = mstatus[MPIE];
        ret_status[MPIE]          = 1'b1;
        ret_status[MPP_HI:MPP_LO] = 2'b11;
        save      = cur inside {SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SET_STATUS, RESTORE_STATUS};
        csr_w     = save || fwd;
        csr_wsc   = save ? WSC_W : fwd ? csr_req_wsc : '0;
        csr_waddr = cur == SAVE_EPC ? MEPC_ADDR : cur == SAVE_CAUSE ? MCAUSE_ADDR :
                    cur == SAVE_TVAL ? MTVAL_ADDR :
                    (cur == SET_STATUS || cur == RESTORE_STATUS) ? MSTATUS_ADDR :
                    fwd ? csr_req_addr : '0;
        csr_wdata = cur == SAVE_EPC ? epc_q : cur == SAVE_CAUSE ? cause_q :
                    cur == SAVE_TVAL ? tval_q : cur == SET_STATUS ? set_status :
                    cur == RESTORE_STATUS ? ret_status : fwd ? csr_req_wdata : '0;
        csr_raddr      = cur == TRAP_JUMP ? MTVEC_ADDR : cur == RET_JUMP ? MEPC_ADDR : csr_req_addr;
        redirect_valid = cur == TRAP_JUMP || cur == RET_JUMP;
        PC_redirect    = cur == TRAP_JUMP ? {csr_rdata[31:2], 2'b00} :
                         cur == RET_JUMP ? csr_rdata : '0;
        unique case (cur)
            IDLE:           next_state = ev ? (is_mret ? RESTORE_STATUS : SAVE_EPC) : IDLE;
            SAVE_EPC:       next_state = SAVE_CAUSE;
            SAVE_CAUSE:     next_state = SAVE_TVAL;
            SAVE_TVAL:      next_state = SET_STATUS;
            SET_STATUS:     next_state = TRAP_JUMP;
            RESTORE_STATUS: next_state = RET_JUMP;
            default:        next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state <= next_state;
            if (trap_ev) begin
                cause_q <= ev_cause;
                epc_q   <= epc_sel ? epc_next : epc_cur;
                tval_q  <= tval_sel ? fault_val : '0;
            end
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: randomized scoreboard bench with a CSR-file environment and a rule-level trap model
module tb_trap_sequencer;
    import trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_req_valid = 1'b0;
    logic [11:0] csr_req_addr = 12'h123;
    logic [31:0] csr_req_wdata = '0;
    logic [1:0]  csr_req_wsc = '0;
    logic        csr_req_ready;
    logic        interrupt = 1'b0, illegal_inst = 1'b0, l_access_fault = 1'b0;
    logic        s_access_fault = 1'b0, ecall_m = 1'b0, mret = 1'b0;
    logic [31:0] epc_cur = '0, epc_next = '0, fault_val = '0;
    logic [31:0] ms_in, csr_rdata;
    logic [11:0] csr_raddr, csr_waddr;
    logic        csr_w, flush, stall, RegWrite_cancel, redirect_valid, busy;
    logic [31:0] csr_wdata, PC_redirect;
    logic [1:0]  csr_wsc;

    trap_sequencer dut (
        .clk(clk), .rst(rst),
        .csr_req_valid(csr_req_valid), .csr_req_addr(csr_req_addr),
        .csr_req_wdata(csr_req_wdata), .csr_req_wsc(csr_req_wsc), .csr_req_ready(csr_req_ready),
        .interrupt(interrupt), .illegal_inst(illegal_inst), .l_access_fault(l_access_fault),
        .s_access_fault(s_access_fault), .ecall_m(ecall_m), .mret(mret),
        .epc_cur(epc_cur), .epc_next(epc_next), .fault_val(fault_val),
        .mstatus(ms_in), .csr_rdata(csr_rdata), .csr_raddr(csr_raddr),
        .csr_w(csr_w), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wsc(csr_wsc),
        .flush(flush), .stall(stall), .RegWrite_cancel(RegWrite_cancel),
        .redirect_valid(redirect_valid), .PC_redirect(PC_redirect), .busy(busy)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] addr;
        logic [31:0] data;
        logic [1:0]  wsc;
    } item_t;

    item_t       q[$];
    int          cyc = 0, checks = 0, errors = 0;
    int          busy_from = 0, busy_until = -1, ev_cyc = -1;
    bit          started = 0;
    logic        mon_busy;
    logic [31:0] env_csr [4096];
    logic [31:0] model [4096];
    string       kind_name [3] = '{"flush", "write", "redirect"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] apply(logic [31:0] o, logic [31:0] d, logic [1:0] w);
        return w == 2'b01 ? d : w == 2'b10 ? (o | d) : w == 2'b11 ? (o & ~d) : o;
    endfunction

    // The environment CSR file: combinational read, written by whatever the DUT drives
    always @(posedge clk) if (csr_w) env_csr[csr_waddr] <= apply(env_csr[csr_waddr], csr_wdata, csr_wsc);
    assign csr_rdata = env_csr[csr_raddr];
    assign ms_in     = env_csr[12'h300];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    function automatic void push(int c, int k, logic [11:0] a, logic [31:0] d, logic [1:0] w);
        q.push_back('{c, k, a, d, w});
    endfunction

    function automatic void observe(int k, logic [11:0] a, logic [31:0] d, logic [1:0] w);
        if (q.size() > 0 && q[0].cyc == cyc && q[0].kind == k) begin
            chk({kind_name[k], " addr"}, 32'(a), 32'(q[0].addr));
            chk({kind_name[k], " data"}, d, q[0].data);
            chk({kind_name[k], " wsc"}, 32'(w), 32'(q[0].wsc));
            void'(q.pop_front());
        end else begin
            checks++;
            errors++;
            $display("FAIL unexpected %s at cycle %0d: got addr %h data %h wsc %0d, nothing required",
                     kind_name[k], cyc, a, d, w);
        end
    endfunction

    // Event evs bits, highest priority first: {interrupt, illegal, ecall, lfault, sfault, mret}
    task automatic drive(input logic [5:0] evs, input logic rv, input logic [11:0] ra,
                         input logic [31:0] rd, input logic [1:0] rw,
                         input logic [31:0] pc_cur, input logic [31:0] pc_nxt, input logic [31:0] fv);
        logic [31:0] ms, ns, cause, epc, tval;
        logic        taken, irq;
        @(posedge clk);
        #1;
        {interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret} = evs;
        csr_req_valid = rv;
        csr_req_addr  = ra;
        csr_req_wdata = rd;
        csr_req_wsc   = rw;
        epc_cur       = pc_cur;
        epc_next      = pc_nxt;
        fault_val     = fv;
        if (cyc > busy_until && rst) begin
            ms = model[12'h300];
            taken = 1'b1;
            irq = 1'b0;
            cause = 0;
            epc = pc_cur;
            tval = 0;
            if (evs[5] && ms[3]) begin irq = 1'b1; cause = 32'h8000000B; epc = pc_nxt; end
            else if (evs[4]) begin cause = 2; tval = fv; end
            else if (evs[3]) cause = 11;
            else if (evs[2]) begin cause = 5; tval = fv; end
            else if (evs[1]) begin cause = 7; tval = fv; end
            else taken = 1'b0;
            if (taken) begin
                ns = ms;
                ns[7] = ms[3];
                ns[3] = 1'b0;
                ns[12:11] = 2'b11;
                push(cyc, 0, 12'h0, {31'b0, !irq}, 2'b00);
                push(cyc + 1, 1, 12'h341, epc, 2'b01);
                push(cyc + 2, 1, 12'h342, cause, 2'b01);
                push(cyc + 3, 1, 12'h343, tval, 2'b01);
                push(cyc + 4, 1, 12'h300, ns, 2'b01);
                push(cyc + 5, 2, 12'h0, {model[12'h305][31:2], 2'b00}, 2'b00);
                model[12'h341] = epc;
                model[12'h342] = cause;
                model[12'h343] = tval;
                model[12'h300] = ns;
                ev_cyc = cyc;
                busy_from = cyc + 1;
                busy_until = cyc + 5;
            end else if (evs[0]) begin
                ns = ms;
                ns[3] = ms[7];
                ns[7] = 1'b1;
                ns[12:11] = 2'b11;
                push(cyc, 0, 12'h0, 32'h0, 2'b00);
                push(cyc + 1, 1, 12'h300, ns, 2'b01);
                push(cyc + 2, 2, 12'h0, model[12'h341], 2'b00);
                model[12'h300] = ns;
                ev_cyc = cyc;
                busy_from = cyc + 1;
                busy_until = cyc + 2;
            end else if (rv) begin
                push(cyc, 1, ra, rd, rw);
                model[ra] = apply(model[ra], rd, rw);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'b0, 1'b0, 12'h0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (started && rst) begin
            mon_busy = cyc >= busy_from && cyc <= busy_until;
            chk("busy", 32'(busy), 32'(mon_busy));
            chk("stall", 32'(stall), 32'(mon_busy));
            chk("csr_req_ready", 32'(csr_req_ready), 32'(!mon_busy && cyc != ev_cyc));
            if (!mon_busy) chk("csr_raddr idle", 32'(csr_raddr), 32'(csr_req_addr));
            if (!flush) chk("RegWrite_cancel without flush", 32'(RegWrite_cancel), 32'h0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing %s for cycle %0d: addr %h data %h required, not seen",
                         kind_name[q[0].kind], q[0].cyc, q[0].addr, q[0].data);
                void'(q.pop_front());
            end
            if (flush) observe(0, 12'h0, {31'b0, RegWrite_cancel}, 2'b00);
            if (csr_w) observe(1, csr_waddr, csr_wdata, csr_wsc);
            if (redirect_valid) observe(2, 12'h0, PC_redirect, 2'b00);
        end
    end

    initial begin
        logic [11:0] addrs [4];
        logic [5:0]  e;
        int          t;
        addrs = '{12'h340, 12'h305, 12'h300, 12'h341};
        for (int i = 0; i < 4096; i++) begin
            env_csr[i] <= 32'h0;
            model[i] = 32'h0;
        end
        env_csr[12'h305] <= 32'h200;
        env_csr[12'h300] <= 32'h8;
        model[12'h305] = 32'h200;
        model[12'h300] = 32'h8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset csr_w", 32'(csr_w), 32'h0);
        chk("reset flush", 32'(flush), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset redirect_valid", 32'(redirect_valid), 32'h0);
        chk("reset csr_req_ready", 32'(csr_req_ready), 32'h1);
        chk("reset csr_raddr", 32'(csr_raddr), 32'h123);
        @(posedge clk);
        #1;
        rst = 1'b1;
        started = 1;

        // illegal instruction trap into mtvec 0x200
        drive(6'b010000, 1'b0, 12'h0, 32'h0, 2'b00, 32'h100, 32'h104, 32'hFFFFFFFF);
        idle(7);
        chk("illegal mepc", env_csr[12'h341], 32'h100);
        chk("illegal mcause", env_csr[12'h342], 32'h2);
        chk("illegal mtval", env_csr[12'h343], 32'hFFFFFFFF);
        chk("illegal mstatus", env_csr[12'h300], 32'h1880);
        // masked interrupt: nothing happens
        drive(6'b100000, 1'b0, 12'h0, 32'h0, 2'b00, 32'h0, 32'h48, 32'h0);
        idle(3);
        // mret back to 0x104 with MPIE=1
        drive(6'b0, 1'b1, 12'h341, 32'h104, 2'b01, 32'h0, 32'h0, 32'h0);
        drive(6'b000001, 1'b0, 12'h0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
        idle(4);
        chk("mret mstatus", env_csr[12'h300], 32'h1888);
        // enabled interrupt
        drive(6'b100000, 1'b0, 12'h0, 32'h0, 2'b00, 32'h60, 32'h48, 32'h77);
        idle(7);
        chk("irq mcause", env_csr[12'h342], 32'h8000000B);
        chk("irq mepc", env_csr[12'h341], 32'h48);
        chk("irq mstatus", env_csr[12'h300], 32'h1880);
        // ecall beats load fault
        drive(6'b001100, 1'b0, 12'h0, 32'h0, 2'b00, 32'h80, 32'h84, 32'hABC);
        idle(7);
        chk("ecall mcause", env_csr[12'h342], 32'd11);
        // pipeline CSRRS while the sequencer is in SAVE_CAUSE is refused
        drive(6'b010000, 1'b0, 12'h0, 32'h0, 2'b00, 32'h90, 32'h94, 32'h1);
        idle(1);
        drive(6'b0, 1'b1, 12'h340, 32'h5, 2'b10, 32'h0, 32'h0, 32'h0);
        idle(5);
        chk("busy CSRRS dropped", env_csr[12'h340], 32'h0);
        drive(6'b0, 1'b1, 12'h340, 32'h5, 2'b10, 32'h0, 32'h0, 32'h0);
        idle(2);
        chk("idle CSRRS applied", env_csr[12'h340], 32'h5);

        for (int i = 0; i < 2500; i++) begin
            e = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            drive(e, 1'($urandom), addrs[$urandom_range(0, 3)], $urandom, 2'($urandom_range(1, 3)),
                  $urandom, $urandom, $urandom);
        end
        idle(8);

        // reset two cycles into a trap aborts the sequence
        drive(6'b010000, 1'b0, 12'h0, 32'h0, 2'b00, 32'h300, 32'h304, 32'hDEAD);
        t = cyc;
        idle(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        while (q.size() > 0 && q[$].cyc >= t + 2) void'(q.pop_back());
        busy_until = t + 2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("busy after reset", 32'(busy), 32'h0);
        idle(6);
        drive(6'b0, 1'b1, 12'h340, 32'h99, 2'b01, 32'h0, 32'h0, 32'h0);
        idle(3);
        chk("write after reset", env_csr[12'h340], 32'h99);
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
